// File: rtl/aesl_deadlock_reporter.sv
// Deadlock reporter: declares a deadlock after THRESHOLD consecutive blocked cycles,
// then holds a valid/ready report. Define AESL_DEADLOCK_REARM_EN to allow repeat reports.
module aesl_deadlock_reporter #(
  parameter int unsigned THRESHOLD = 16,
  parameter int unsigned INFO_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              block,
  input  logic [INFO_W-1:0] axis_block_info,
  output logic              report_valid,
  input  logic              report_ready,
  output logic [INFO_W-1:0] report_info,
  output logic [31:0]       report_cycle,
  output logic              deadlock,
  output logic              finish_req
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [15:0] THRESH = 16'(THRESHOLD);

  logic [1:0]  state;
  logic [15:0] persist;
  logic [31:0] cycle_cnt;
  logic        blocked;
  logic        declare;

  assign blocked      = enable && block;
  assign report_valid = (state == REPORT);

  // Declaration happens on the THRESHOLD-th blocked cycle itself, so the count
  // before that edge is THRESHOLD-1 (or the block is still in IDLE when THRESHOLD is 1).
  always_comb begin
    declare = blocked &&
              (((state == IDLE) && (THRESH == 16'd1)) ||
               ((state == COUNT) && ((persist + 16'd1) == THRESH)));
  end

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values; the latched report fields are reset too so they read 0 after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      persist      <= '0;
      cycle_cnt    <= '0;
      report_info  <= '0;
      report_cycle <= '0;
      deadlock     <= 1'b0;
      finish_req   <= 1'b0;
    end else begin
      finish_req <= 1'b0;
      if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;

      if (declare) begin
        state        <= REPORT;
        persist      <= THRESH;
        report_info  <= axis_block_info;
        report_cycle <= cycle_cnt;
      end else begin
        case (state)
          IDLE: begin
            if (blocked) begin
              state   <= COUNT;
              persist <= 16'd1;
            end
          end
          COUNT: begin
            if (blocked) begin
              persist <= persist + 16'd1;
            end else begin
              state   <= IDLE;
              persist <= '0;
            end
          end
          REPORT: begin
            if (report_ready) begin
              state      <= DONE;
              deadlock   <= 1'b1;
              finish_req <= 1'b1;
            end
          end
          default: begin
`ifdef AESL_DEADLOCK_REARM_EN
            if (!block) begin
              state   <= IDLE;
              persist <= '0;
            end
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: doc/aesl_deadlock_reporter.md
AESL_DEADLOCK_REPORTER -- requirements
Module: aesl_deadlock_reporter

Interface
REQ-001 Parameter THRESHOLD, default 16: consecutive blocked cycles required before a deadlock is declared; legal range 1..65535.
REQ-002 Parameter INFO_W, default 4: width of the channel block-info vector.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: detection enable; while low, the persistence counter holds at 0.
REQ-006 The block SHALL have port block, input, 1 bit: the deadlock-monitor block indication.
REQ-007 The block SHALL have port axis_block_info, input, INFO_W bits: the monitor's per-channel block info, valid while block is high.
REQ-008 The block SHALL have port report_valid, output, 1 bit: a deadlock report is pending.
REQ-009 The block SHALL have port report_ready, input, 1 bit: the consumer accepts the report.
REQ-010 The block SHALL have port report_info, output, INFO_W bits: the latched channel info.
REQ-011 The block SHALL have port report_cycle, output, 32 bits: the cycle stamp at declaration.
REQ-012 The block SHALL have port deadlock, output, 1 bit: sticky indication that at least one report was accepted.
REQ-013 The block SHALL have port finish_req, output, 1 bit: one-cycle pulse on report acceptance.

Function
REQ-014 States SHALL be IDLE, COUNT, REPORT and DONE.
REQ-015 A free-running 32-bit cycle counter SHALL start at 0 after reset, increment every cycle and saturate at 0xFFFFFFFF.
REQ-016 From IDLE, enable=1 and block=1 SHALL move the block to COUNT with a persistence count of 1.
REQ-017 In COUNT, block=1 and enable=1 SHALL increment the count; block=0 or enable=0 SHALL clear the count and return to IDLE in the same edge.
REQ-018 When the count equals THRESHOLD with block=1, the block SHALL latch axis_block_info into report_info and the cycle counter into report_cycle, and enter REPORT.
REQ-019 THRESHOLD=1 SHALL declare on the first blocked cycle: IDLE goes directly to REPORT.
REQ-020 report_valid SHALL be high only in REPORT; report_info and report_cycle SHALL be stable while report_valid is high, regardless of block or axis_block_info.
REQ-021 The handshake SHALL complete on a cycle with report_valid=1 and report_ready=1; on that edge the block enters DONE, sets deadlock=1 and pulses finish_req for exactly one cycle.
REQ-022 report_ready while not in REPORT SHALL be ignored.
REQ-023 The block SHALL not drop block or enable once in REPORT; the report stays pending until accepted.
REQ-024 The persistence counter SHALL be 16 bits wide and SHALL never wrap, since it stops at THRESHOLD.

Reset
REQ-025 Asserting reset low SHALL immediately force the following outputs: state IDLE, counters 0, report_valid=0, report_info=0, report_cycle=0, deadlock=0, finish_req=0.
REQ-026 A reset asserted in mid-REPORT or mid-COUNT SHALL discard the pending report with no finish_req pulse.
REQ-027 Deassertion SHALL be taken synchronously to clock; the first count occurs on the first rising edge after deassertion.

Configuration
REQ-028 With AESL_DEADLOCK_REARM_EN defined, DONE SHALL return to IDLE on the first cycle with block=0, allowing further reports; deadlock remains sticky.
REQ-029 Without AESL_DEADLOCK_REARM_EN, DONE SHALL be terminal until reset; block and report_ready are ignored.

Verification
REQ-030 Scenario: THRESHOLD=16, enable=1, block high 16 cycles from cycle 10, info=4'b1010 -> report_valid rises at cycle 26, report_info=4'b1010, report_cycle=25.
REQ-031 Scenario: block high 15 cycles, low 1, high 16 -> exactly one report, declared on the 16th cycle of the second run.
REQ-032 Scenario: report_ready held low 20 cycles while info toggles -> report_valid stays high and report_info is unchanged; ready=1 -> one finish_req pulse, deadlock=1.
REQ-033 Scenario: THRESHOLD=1, block=1 at cycle 5 -> report_valid=1 at cycle 6.
REQ-034 Scenario: reset pulled low during REPORT -> all outputs 0 immediately, no finish_req.
REQ-035 Scenario: second blocked run after acceptance -> a second report when AESL_DEADLOCK_REARM_EN is defined, none otherwise.
